// File: rtl/subtrator_mux_serial_pkg.sv
// -----------------------------------------------------------------------------
// subtrator_pkg
// Shared definitions for the bit-serial subtractor/mux block.
//   state_t        : FSM encoding (IDLE, SHIFT, DONE)
//   DEFAULT_WIDTH  : default operand/result width
// -----------------------------------------------------------------------------
package subtrator_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : subtrator_pkg

// File: rtl/subtrator_mux_serial_if.sv
// -----------------------------------------------------------------------------
// subtrator_mux_serial_if
// Operand/handshake bundle for subtrator_mux_serial.
//   start   : request, accepted in IDLE or DONE
//   ia      : minuend
//   ib, ic  : subtrahend candidates, chosen by select
//   select  : 0 -> ib, 1 -> ic (sampled with start)
//   busy    : high while the serial subtraction is running
//   done    : one-cycle completion pulse
//   out_sub : ia - subtrahend, modulo 2^WIDTH
//   borrow  : 1 iff ia < subtrahend (unsigned)
// The master drives requests/operands; the slave (the datapath) drives results.
// -----------------------------------------------------------------------------
interface subtrator_mux_serial_if
    import subtrator_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] ia;
    logic [WIDTH-1:0] ib;
    logic [WIDTH-1:0] ic;
    logic             select;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out_sub;
    logic             borrow;

    modport master (
        output start, ia, ib, ic, select,
        input  busy, done, out_sub, borrow
    );

    modport slave (
        input  start, ia, ib, ic, select,
        output busy, done, out_sub, borrow
    );

endinterface : subtrator_mux_serial_if

// File: rtl/subtrator_mux_serial_full_subtrator_1bit.sv
// -----------------------------------------------------------------------------
// full_subtrator_1bit
// Combinational one-bit full subtractor: computes a - b - bin.
//   a, b  : operand bits
//   bin   : borrow in from the less significant bit
//   d     : difference bit
//   bout  : borrow out to the more significant bit
// -----------------------------------------------------------------------------
module full_subtrator_1bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    // Borrow when b exceeds a, or when they are equal and a borrow is pending.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : full_subtrator_1bit

// File: rtl/subtrator_mux_serial.sv
// -----------------------------------------------------------------------------
// subtrator_mux_serial
// Bit-serial subtractor: result = ia - (select ? ic : ib), LSB first, one bit
// per clock, with a start/done handshake and an unsigned borrow flag.
//   clk   : clock, everything on posedge
//   rst_n : synchronous active-low reset
//   bus   : operand/result bundle (slave side), see subtrator_mux_serial_if
// Operands are latched when start is accepted, so later input changes do not
// affect the running operation. Results hold after done until the next
// accepted start clears them.
// -----------------------------------------------------------------------------
module subtrator_mux_serial
    import subtrator_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    subtrator_mux_serial_if.slave   bus
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t            state_q,  state_d;
    logic [WIDTH-1:0]  a_q,      a_d;
    logic [WIDTH-1:0]  b_q,      b_d;
    logic [CW-1:0]     cnt_q,    cnt_d;
    logic              bw_q,     bw_d;
    logic [WIDTH-1:0]  out_q,    out_d;
    logic              borrow_q, borrow_d;

    logic              bit_d;
    logic              bit_bout;

    // Single shared bit slice, walked across the operands by cnt_q.
    full_subtrator_1bit u_fs (
        .a    (a_q[cnt_q]),
        .b    (b_q[cnt_q]),
        .bin  (bw_q),
        .d    (bit_d),
        .bout (bit_bout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            bw_q     <= 1'b0;
            out_q    <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            bw_q     <= bw_d;
            out_q    <= out_d;
            borrow_q <= borrow_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        bw_d     = bw_q;
        out_d    = out_q;
        borrow_d = borrow_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d  = SHIFT;
                    a_d      = bus.ia;
                    b_d      = bus.select ? bus.ic : bus.ib;
                    cnt_d    = '0;
                    bw_d     = 1'b0;
                    out_d    = '0;
                    borrow_d = 1'b0;
                end else begin
                    state_d  = IDLE;
                end
            end
            SHIFT: begin
                out_d[cnt_q] = bit_d;
                bw_d         = bit_bout;
                if (cnt_q == LAST_BIT) begin
                    // Counter stays on the top bit; it is reloaded on the next start.
                    state_d  = DONE;
                    borrow_d = bit_bout;
                end else begin
                    cnt_d    = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy    = (state_q == SHIFT);
    assign bus.done    = (state_q == DONE);
    assign bus.out_sub = out_q;
    assign bus.borrow  = borrow_q;

endmodule : subtrator_mux_serial
